// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory.
// Read responses are steered back to their requester via a LATENCY-deep tag pipeline.
module mem_arbiter #(
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]         starve_cnt;
    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] own_p;
    logic               i_win;
    logic               push_vld;

    // Grant stage: data wins unless the fetch side has waited STARVE_LIMIT grants.
    always_comb begin
        i_win    = i_req && (!d_req || (starve_cnt == LIMIT));
        i_gnt    = reset && i_win;
        d_gnt    = reset && d_req && !i_win;
        m_en     = i_gnt || d_gnt;
        m_we     = d_gnt && d_we;
        m_addr   = d_gnt ? d_addr : (i_gnt ? i_addr : 32'd0);
        m_wdata  = d_gnt ? d_wdata : 32'd0;
        push_vld = i_gnt || (d_gnt && !d_we);
    end

    // Response stage: the tag leaving the pipeline selects which port sees m_rdata.
    always_comb begin
        i_valid = reset && vld_p[LATENCY-1] && !own_p[LATENCY-1];
        d_valid = reset && vld_p[LATENCY-1] &&  own_p[LATENCY-1];
        i_rdata = i_valid ? m_rdata : 32'd0;
        d_rdata = d_valid ? m_rdata : 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            vld_p      <= '0;
            own_p      <= '0;
        end else begin
            vld_p[0] <= push_vld;
            own_p[0] <= d_gnt;
            for (int k = 1; k < LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
                own_p[k] <= own_p[k-1];
            end
            if (i_gnt || !i_req) begin
                starve_cnt <= '0;
            end else if (d_gnt && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=1 instance driven from a vector table,
// and a LATENCY=3 instance sharing the same inputs for pipelined-order and reset cases.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] m_rdata = '0;

    logic        i_gnt1, i_valid1, d_gnt1, d_valid1, m_en1, m_we1;
    logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1;
    logic        i_gnt3, i_valid3, d_gnt3, d_valid3, m_en3, m_we3;
    logic [31:0] i_rdata3, d_rdata3, m_addr3, m_wdata3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_valid(i_valid1), .i_rdata(i_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_valid(d_valid1), .d_rdata(d_rdata1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata)
    );

    mem_arbiter #(.LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt3), .i_valid(i_valid3), .i_rdata(i_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_valid(d_valid3), .d_rdata(d_rdata3),
        .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata)
    );

    typedef struct {
        logic        i_req, d_req, d_we;
        logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
        logic        e_igt, e_dgt, e_iv, e_dv;
        logic [31:0] e_ird, e_drd;
        logic        e_men, e_mwe;
        logic [31:0] e_maddr, e_mwd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero1(input string tag);
        chk({tag, "_i_gnt1"}, {31'd0, i_gnt1}, 32'd0);
        chk({tag, "_d_gnt1"}, {31'd0, d_gnt1}, 32'd0);
        chk({tag, "_i_valid1"}, {31'd0, i_valid1}, 32'd0);
        chk({tag, "_d_valid1"}, {31'd0, d_valid1}, 32'd0);
        chk({tag, "_m_en1"}, {31'd0, m_en1}, 32'd0);
        chk({tag, "_m_we1"}, {31'd0, m_we1}, 32'd0);
        chk({tag, "_m_addr1"}, m_addr1, 32'd0);
        chk({tag, "_m_wdata1"}, m_wdata1, 32'd0);
        chk({tag, "_i_rdata1"}, i_rdata1, 32'd0);
        chk({tag, "_d_rdata1"}, d_rdata1, 32'd0);
        chk({tag, "_gnt3"}, {30'd0, i_gnt3, d_gnt3}, 32'd0);
        chk({tag, "_valid3"}, {30'd0, i_valid3, d_valid3}, 32'd0);
        chk({tag, "_m_en3"}, {31'd0, m_en3}, 32'd0);
    endtask

    initial begin
        //           ireq dreq we  i_addr        d_addr        d_wdata       m_rdata         igt dgt iv dv  ird           drd           men mwe maddr        mwd
        vecs[0]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        32'h0};
        vecs[1]  = '{1'b1,1'b0,1'b0,32'h00400000,32'h0,        32'h0,        32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h00400000,32'h0};
        vecs[2]  = '{1'b0,1'b0,1'b0,32'h00400000,32'h0,        32'h0,        32'h20080005,1'b0,1'b0,1'b1,1'b0,32'h20080005,32'h0,        1'b0,1'b0,32'h0,        32'h0};
        vecs[3]  = '{1'b1,1'b1,1'b0,32'h00400004,32'h10010000,32'h0,        32'h11111111,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h10010000,32'h0};
        vecs[4]  = '{1'b1,1'b0,1'b0,32'h00400004,32'h10010000,32'h0,        32'h22222222,1'b1,1'b0,1'b0,1'b1,32'h0,        32'h22222222,1'b1,1'b0,32'h00400004,32'h0};
        vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h33333333,1'b0,1'b0,1'b1,1'b0,32'h33333333,32'h0,        1'b0,1'b0,32'h0,        32'h0};
        vecs[6]  = '{1'b0,1'b1,1'b1,32'h0,        32'h10010004,32'hDEADBEEF,32'h44444444,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b1,32'h10010004,32'hDEADBEEF};
        vecs[7]  = '{1'b0,1'b0,1'b0,32'h0,        32'h10010004,32'hDEADBEEF,32'h55555555,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        32'h0};
        vecs[8]  = '{1'b0,1'b1,1'b0,32'h0,        32'h10010008,32'hCAFEF00D,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,32'h10010008,32'hCAFEF00D};
        vecs[9]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h66666666,1'b0,1'b0,1'b0,1'b1,32'h0,        32'h66666666,1'b0,1'b0,32'h0,        32'h0};
        vecs[10] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h77777777,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        32'h0};

        // Held in reset with both requests asserted: everything stays quiet.
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h00400000; d_addr = 32'h10010000; m_rdata = 32'h12345678;
        @(negedge clk); #1;
        chk_all_zero1("rst");
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0; m_rdata = '0;
        reset = 1'b1;

        for (int n = 0; n < 11; n++) begin
            @(negedge clk);
            i_req = vecs[n].i_req; d_req = vecs[n].d_req; d_we = vecs[n].d_we;
            i_addr = vecs[n].i_addr; d_addr = vecs[n].d_addr;
            d_wdata = vecs[n].d_wdata; m_rdata = vecs[n].m_rdata;
            #1;
            chk($sformatf("v%0d_i_gnt", n), {31'd0, i_gnt1}, {31'd0, vecs[n].e_igt});
            chk($sformatf("v%0d_d_gnt", n), {31'd0, d_gnt1}, {31'd0, vecs[n].e_dgt});
            chk($sformatf("v%0d_i_valid", n), {31'd0, i_valid1}, {31'd0, vecs[n].e_iv});
            chk($sformatf("v%0d_d_valid", n), {31'd0, d_valid1}, {31'd0, vecs[n].e_dv});
            chk($sformatf("v%0d_i_rdata", n), i_rdata1, vecs[n].e_ird);
            chk($sformatf("v%0d_d_rdata", n), d_rdata1, vecs[n].e_drd);
            chk($sformatf("v%0d_m_en", n), {31'd0, m_en1}, {31'd0, vecs[n].e_men});
            chk($sformatf("v%0d_m_we", n), {31'd0, m_we1}, {31'd0, vecs[n].e_mwe});
            chk($sformatf("v%0d_m_addr", n), m_addr1, vecs[n].e_maddr);
            chk($sformatf("v%0d_m_wdata", n), m_wdata1, vecs[n].e_mwd);
        end

        // Starvation: both held high, fetch wins after every four data grants.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
            i_addr = 32'h00400100; d_addr = 32'h10010100; d_wdata = '0; m_rdata = '0;
            #1;
            chk($sformatf("starve%0d_i_gnt", c), {31'd0, i_gnt1}, (c == 4 || c == 9) ? 32'd1 : 32'd0);
            chk($sformatf("starve%0d_d_gnt", c), {31'd0, d_gnt1}, (c == 4 || c == 9) ? 32'd0 : 32'd1);
            chk($sformatf("starve%0d_i_gnt3", c), {31'd0, i_gnt3}, (c == 4 || c == 9) ? 32'd1 : 32'd0);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_req = 1'b0; d_req = 1'b0; m_rdata = '0;
        end

        // LATENCY=3: alternating fetch/data reads, responses in grant order.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            i_req = (c == 0 || c == 2); d_req = (c == 1 || c == 3); d_we = 1'b0;
            i_addr = 32'h00400200 + 32'(c); d_addr = 32'h10010200 + 32'(c);
            m_rdata = 32'hA0000000 + 32'(c);
            #1;
            chk($sformatf("l3_%0d_i_gnt", c), {31'd0, i_gnt3}, (c == 0 || c == 2) ? 32'd1 : 32'd0);
            chk($sformatf("l3_%0d_d_gnt", c), {31'd0, d_gnt3}, (c == 1 || c == 3) ? 32'd1 : 32'd0);
            chk($sformatf("l3_%0d_i_valid", c), {31'd0, i_valid3}, (c == 3 || c == 5) ? 32'd1 : 32'd0);
            chk($sformatf("l3_%0d_d_valid", c), {31'd0, d_valid3}, (c == 4 || c == 6) ? 32'd1 : 32'd0);
            chk($sformatf("l3_%0d_i_rdata", c), i_rdata3, (c == 3 || c == 5) ? 32'hA0000000 + 32'(c) : 32'd0);
            chk($sformatf("l3_%0d_d_rdata", c), d_rdata3, (c == 4 || c == 6) ? 32'hA0000000 + 32'(c) : 32'd0);
        end

        // Reset pulse while a data read is in flight in both instances.
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010300; m_rdata = 32'hBBBB0000;
        #1;
        chk("mid_d_gnt1", {31'd0, d_gnt1}, 32'd1);
        chk("mid_d_gnt3", {31'd0, d_gnt3}, 32'd1);
        @(negedge clk);
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h00400300; m_rdata = 32'hBBBB0001;
        reset = 1'b0;
        #1;
        chk_all_zero1("midrst_a");
        @(negedge clk); #1;
        chk_all_zero1("midrst_b");
        @(negedge clk);
        reset = 1'b1; i_req = 1'b0; i_addr = '0;
        for (int c = 0; c < 4; c++) begin
            m_rdata = 32'hBBBB0010 + 32'(c);
            #1;
            chk($sformatf("post%0d_valid1", c), {30'd0, i_valid1, d_valid1}, 32'd0);
            chk($sformatf("post%0d_valid3", c), {30'd0, i_valid3, d_valid3}, 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
